// File: rtl/ea_mon_pkg.sv
// ea_mon_pkg: shared types for the event monitor capture sequencer
package ea_mon_pkg;
  localparam int CAP_STATE_W = 3;
  typedef enum logic [CAP_STATE_W-1:0] {
    IDLE  = 3'd0,
    PRE   = 3'd1,
    ARMED = 3'd2,
    POST  = 3'd3,
    DONE  = 3'd4
  } cap_state_e;
endpackage

// File: rtl/wrap_ptr.sv
// wrap_ptr: circular buffer pointer with clear, increment and a wrap pulse
module wrap_ptr #(
  parameter int DEPTH = 256,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              inc,
  output logic [ADDR_W-1:0] ptr,
  output logic              wrap
);
  assign wrap = inc & (ptr == ADDR_W'(DEPTH - 1));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ptr <= '0;
    else ptr <= clr ? '0 : inc ? ptr + 1'b1 : ptr;
endmodule

// File: rtl/capture_seq_ctrl.sv
// capture_seq_ctrl: pre/post trigger capture sequencer for a circular sample buffer
module capture_seq_ctrl
  import ea_mon_pkg::*;
#(
  parameter int DEPTH = 256,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   abort,
  input  logic [ADDR_W-1:0]      cfg_pre,
  input  logic [ADDR_W-1:0]      cfg_post,
  input  logic                   sample_valid,
  input  logic                   trigger_hit,
  output logic                   trig_en,
  output logic                   trig_arm,
  output logic                   buf_we,
  output logic [ADDR_W-1:0]      buf_waddr,
  output logic [ADDR_W-1:0]      trig_addr,
  output logic                   wrapped,
  output logic                   busy,
  output logic                   done,
  output logic                   cfg_err,
  output logic [CAP_STATE_W-1:0] state
);
  cap_state_e st, st_nx;
  logic [ADDR_W-1:0] pre_q, post_q, pre_cnt, post_cnt, wptr;
  logic [ADDR_W:0] cfg_sum;
  logic active, go, bad, ok, hit, wrap;
  assign active    = (st == PRE) | (st == ARMED) | (st == POST);
  assign cfg_sum   = {1'b0, cfg_pre} + {1'b0, cfg_post};
  assign go        = start & ~abort & ((st == IDLE) | (st == DONE));
  assign bad       = cfg_sum > (ADDR_W+1)'(DEPTH - 1);
  assign ok        = go & ~bad;
  assign buf_we    = sample_valid & active & ~abort;
  assign hit       = (st == ARMED) & trigger_hit & buf_we;
  assign trig_en   = sample_valid & active;
  assign trig_arm  = st == ARMED;
  assign buf_waddr = wptr;
  assign busy      = active;
  assign done      = st == DONE;
  assign state     = st;
  wrap_ptr #(.DEPTH(DEPTH)) u_wptr (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (ok),
    .inc  (buf_we),
    .ptr  (wptr),
    .wrap (wrap)
  );
  always_comb begin
    st_nx = st;
    if (abort) st_nx = IDLE;
    else if (go) st_nx = bad ? IDLE : PRE;
    else
      unique case (st)
        PRE:   st_nx = ((pre_q == '0) | (buf_we & (pre_cnt + 1'b1 == pre_q))) ? ARMED : PRE;
        ARMED: st_nx = hit ? ((post_q == '0) ? DONE : POST) : ARMED;
        POST:  st_nx = (buf_we & (post_cnt == ADDR_W'(1))) ? DONE : POST;
        default: st_nx = st;
      endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st        <= IDLE;
      pre_q     <= '0;
      post_q    <= '0;
      pre_cnt   <= '0;
      post_cnt  <= '0;
      trig_addr <= '0;
      wrapped   <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      st      <= st_nx;
      cfg_err <= go & bad;
      if (ok) begin
        pre_q   <= cfg_pre;
        post_q  <= cfg_post;
        pre_cnt <= '0;
      end else if ((st == PRE) & buf_we) pre_cnt <= pre_cnt + 1'b1;
      if (hit) post_cnt <= post_q;
      else if ((st == POST) & buf_we) post_cnt <= post_cnt - 1'b1;
      trig_addr <= abort ? '0 : hit ? wptr : trig_addr;
      wrapped   <= (abort | ok) ? 1'b0 : wrapped | wrap;
    end
endmodule

// File: tb/tb_capture_seq_ctrl.sv
// tb_capture_seq_ctrl: directed checks of capture sequencing at DEPTH=16
module tb_capture_seq_ctrl;
  import ea_mon_pkg::*;
  localparam int DEPTH = 16;
  localparam int AW = 4;
  logic clk = 0, rst_n = 0, start = 0, abort = 0, sample_valid = 0, trigger_hit = 0;
  logic [AW-1:0] cfg_pre = '0, cfg_post = '0;
  logic trig_en, trig_arm, buf_we, wrapped, busy, done, cfg_err;
  logic [AW-1:0] buf_waddr, trig_addr;
  logic [2:0] state;
  int errs = 0, checks = 0, nwr = 0, first_wa = -1, last_wa = -1, seq_bad = 0;

  always #5 clk = ~clk;

  capture_seq_ctrl #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .cfg_pre(cfg_pre), .cfg_post(cfg_post), .sample_valid(sample_valid),
    .trigger_hit(trigger_hit), .trig_en(trig_en), .trig_arm(trig_arm),
    .buf_we(buf_we), .buf_waddr(buf_waddr), .trig_addr(trig_addr),
    .wrapped(wrapped), .busy(busy), .done(done), .cfg_err(cfg_err), .state(state)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clr_log();
    nwr = 0; seq_bad = 0; first_wa = -1; last_wa = -1;
  endtask

  // one clock: drive at negedge, log writes 1ns later, return at next negedge
  task automatic tick(input logic v, input logic h, input logic a = 1'b0);
    sample_valid = v; trigger_hit = h; abort = a;
    #1;
    if (buf_we) begin
      if (nwr == 0) first_wa = int'(buf_waddr);
      else if (int'(buf_waddr) != (last_wa + 1) % DEPTH) seq_bad++;
      last_wa = int'(buf_waddr);
      nwr++;
    end
    @(negedge clk);
    sample_valid = 0; trigger_hit = 0; abort = 0;
  endtask

  task automatic start_cap(input int p, input int q);
    cfg_pre = AW'(p); cfg_post = AW'(q); start = 1;
    tick(0, 0);
    start = 0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_state", state, IDLE);
    chk("rst_busy", busy, 0);
    chk("rst_trig_addr", trig_addr, 0);
    chk("rst_waddr", buf_waddr, 0);
    rst_n = 1;
    @(negedge clk);

    // 1: pre=4 post=3, hit on 7th sample
    clr_log();
    start_cap(4, 3);
    chk("t1_pre", state, PRE);
    for (int i = 0; i < 40 && !done; i++) begin
      tick(1, i == 6);
      if (i == 3) chk("t1_armed", state, ARMED);
    end
    chk("t1_done", done, 1);
    chk("t1_nwr", nwr, 10);
    chk("t1_first", first_wa, 0);
    chk("t1_last", last_wa, 9);
    chk("t1_seq", seq_bad, 0);
    chk("t1_trig_addr", trig_addr, 6);
    chk("t1_wrapped", wrapped, 0);

    // 2: pre=0 post=0, restarted from DONE
    clr_log();
    start_cap(0, 0);
    chk("t2_pre", state, PRE);
    tick(0, 0);
    chk("t2_armed", state, ARMED);
    chk("t2_arm_out", trig_arm, 1);
    tick(1, 1);
    chk("t2_done", state, DONE);
    chk("t2_nwr", nwr, 1);
    chk("t2_addr", first_wa, 0);
    chk("t2_trig_addr", trig_addr, 0);

    // 3: pre=2 post=13, hit after 20 armed samples, buffer wraps
    clr_log();
    start_cap(2, 13);
    for (int i = 0; i < 80 && !done; i++) begin
      tick(1, i == 22);
      if (i == 21) chk("t3_still_armed", state, ARMED);
    end
    chk("t3_done", done, 1);
    chk("t3_nwr", nwr, 36);
    chk("t3_last", last_wa, 3);
    chk("t3_seq", seq_bad, 0);
    chk("t3_trig_addr", trig_addr, 6);
    chk("t3_wrapped", wrapped, 1);

    // 4: over-size config rejected, then boundary sum accepted
    clr_log();
    cfg_pre = 10; cfg_post = 6; start = 1;
    tick(1, 0);
    start = 0;
    chk("t4_err", cfg_err, 1);
    chk("t4_idle", state, IDLE);
    chk("t4_wrapped_kept", wrapped, 1);
    tick(1, 0);
    chk("t4_err_pulse", cfg_err, 0);
    chk("t4_nwr", nwr, 0);
    start_cap(10, 5);
    chk("t4_edge_ok", state, PRE);
    chk("t4_edge_err", cfg_err, 0);
    chk("t4_wrap_clr", wrapped, 0);
    tick(0, 0, 1);
    chk("t4_abort", state, IDLE);

    // 5: abort with hit+valid in ARMED; start+abort together
    clr_log();
    start_cap(1, 2);
    tick(1, 0);
    chk("t5_armed", state, ARMED);
    tick(1, 1, 1);
    chk("t5_idle", state, IDLE);
    chk("t5_nwr", nwr, 1);
    chk("t5_trig_addr", trig_addr, 0);
    start = 1;
    tick(0, 0, 1);
    start = 0;
    chk("t5_start_abort", state, IDLE);

    // 6: gapped valid, hits only while valid is low
    clr_log();
    start_cap(0, 1);
    tick(0, 0);
    for (int c = 0; c < 9; c++) begin
      sample_valid = (c % 3 == 0); trigger_hit = (c % 3 == 1);
      #1;
      chk("t6_trig_en", trig_en, c % 3 == 0);
      if (buf_we) nwr++;
      @(negedge clk);
    end
    sample_valid = 0; trigger_hit = 0;
    chk("t6_armed", state, ARMED);
    chk("t6_nwr", nwr, 3);

    // asynchronous reset mid-capture
    #2 rst_n = 0;
    #1;
    chk("rst_mid_state", state, IDLE);
    chk("rst_mid_waddr", buf_waddr, 0);
    @(negedge clk);
    rst_n = 1;

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
